id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.
//  Captures decoded operands and control from ID and presents them to EX.
//  Its ex_rs1/ex_rs2 outputs feed the EX-stage forwarding logic; ex_reg_write/ex_rd flow on to EX/MEM.
//  Emits load_use_stall to freeze PC and IF/ID. Counts the bubbles it inserts, for performance monitoring.
// PARAMETERS
//  XLEN    64  datapath width: PC, register data, immediate
//  CNT_W   32  width of the saturating bubble counter
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     asynchronous, active-high reset
//  hold            in   1     global pipeline freeze (memory wait); register keeps contents
//  flush           in   1     branch/jump taken in EX; squash instruction entering EX
//  id_valid        in   1     ID holds a real instruction
//  id_pc           in   XLEN  PC of ID instruction
//  id_rs1,id_rs2   in   5     source register indices
//  id_rd           in   5     destination register index
//  id_uses_rs2     in   1     instruction reads rs2 (R/S/B types)
//  id_rs1_data     in   XLEN  register-file read data 1
//  id_rs2_data     in   XLEN  register-file read data 2
//  id_imm          in   XLEN  sign-extended immediate
//  id_funct4       in   4     {funct7[5],funct3} for ALU control
//  id_ctrl         in   8     {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,alu_op[1:0]}
//  ex_valid        out  1     EX slot holds a real instruction
//  ex_pc,ex_rs1_data,ex_rs2_data,ex_imm  out XLEN  registered copies
//  ex_rs1,ex_rs2,ex_rd                   out 5     registered indices
//  ex_funct4       out  4     registered funct bits
//  ex_ctrl         out  8     registered control; all-zero when bubble
//  load_use_stall  out  1     combinational; 1 = hold PC and IF/ID this cycle
//  bubble_cnt      out  CNT_W number of bubbles inserted, saturating
// BEHAVIOUR
//  Reset (async): ex_valid=0, ex_ctrl=0, all data/index outputs=0, bubble_cnt=0.
//  load_use_stall = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid
//      & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)); forced 0 when flush=1.
//  Per clock edge, first matching rule applies:
//   1 hold=1: all registers keep value; bubble_cnt unchanged. load_use_stall still driven.
//   2 flush=1: ex_valid<=0, ex_ctrl<=0; data/index fields load from ID (don't-care).
//   3 load_use_stall=1: bubble: ex_valid<=0, ex_ctrl<=0, ex_rd<=0; bubble_cnt+=1
//     (saturates at all-ones).
//   4 otherwise: load all fields from ID. ex_valid<=id_valid; ex_ctrl<=id_valid?id_ctrl:0.
//  Latency: 1 cycle ID->EX. A load-use pair costs exactly one bubble; on the next cycle
//  ex_mem_read=0, so the stall releases automatically.
//  A bubble must never assert reg_write or mem_write; the forwarding logic relies on ex_rd=0 for bubbles.
//  flush is held stable by its source while hold=1. Reset mid-stall clears the stall next evaluation.
//  hold and flush are synchronous.
// STRUCTURE
//  Shared header pipeline_defs.vh:
//   - ctrl bit positions CTRL_REG_WRITE..CTRL_ALU_OP
//   - CTRL_W=8
//   - BUBBLE_CTRL=8'h00
//   - ALU_OP encodings
//  Sub-module load_use_detect (combinational compare -> load_use_stall).
//  The register and bubble counter stay in this module.
// TESTING
//  1 ld x5 ; add x6,x5,x7 back-to-back -> load_use_stall=1 one cycle; next ex_ctrl=0, ex_valid=0;
//    bubble_cnt=1; add enters EX the following cycle.
//  2 ld x0 ; add x6,x0,x1 -> no stall (rd=0); add enters EX next cycle.
//  3 ld x5 ; addi x6,x8,4 with id_rs2 field=5, id_uses_rs2=0 -> no stall.
//  4 flush=1 and hazard at the same edge -> load_use_stall=0; ex_valid=0; bubble_cnt unchanged.
//  5 hold=1 for 3 cycles during hazard -> outputs frozen, bubble_cnt unchanged;
//    on release exactly one bubble is inserted.
//  6 preload bubble_cnt near max (CNT_W=4), 16 hazards -> counter sticks at 4'hF;
//    async reset mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: control-word layout, bubble encoding and
// ALU operation classes used by the ID/EX register and its hazard logic.
package id_ex_stage_reg_pkg;

    // Control word width and bit positions:
    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
    localparam int unsigned CTRL_W          = 8;
    localparam int unsigned CTRL_REG_WRITE  = 7;
    localparam int unsigned CTRL_MEM_READ   = 6;
    localparam int unsigned CTRL_MEM_WRITE  = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 4;
    localparam int unsigned CTRL_ALU_SRC    = 3;
    localparam int unsigned CTRL_BRANCH     = 2;
    localparam int unsigned CTRL_ALU_OP     = 0;
    localparam int unsigned CTRL_ALU_OP_W   = 2;

    // Index and funct field widths
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FUNCT4_W  = 4;

    // A bubble carries no side effects: no register write, no memory access
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 8'h00;

    // ALU operation classes carried in ctrl[1:0]
    typedef enum logic [CTRL_ALU_OP_W-1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_e;

    function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

    function automatic logic ctrl_reg_write(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REG_WRITE];
    endfunction

    function automatic logic ctrl_mem_write(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_WRITE];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a register
// that the load currently in EX has not yet produced.
module load_use_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic                 flush,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    output logic                 load_use_stall
);

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;

    // x0 is never a real dependency; a squashed instruction never stalls
    always_comb begin
        ex_is_load     = ex_valid & ex_mem_read & (ex_rd != '0);
        rs1_match      = (ex_rd == id_rs1);
        rs2_match      = id_uses_rs2 & (ex_rd == id_rs2);
        load_use_stall = ~flush & ex_is_load & id_valid & (rs1_match | rs2_match);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of inserted bubbles for performance monitoring.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_uses_rs2,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [FUNCT4_W-1:0]  id_funct4,
    input  logic [CTRL_W-1:0]    id_ctrl,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [FUNCT4_W-1:0]  ex_funct4,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic                 load_use_stall,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic ex_mem_read;

    assign ex_mem_read = ctrl_mem_read(ex_ctrl);

    load_use_detect u_load_use_detect (
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs2    (id_uses_rs2),
        .load_use_stall (load_use_stall)
    );

    // Pipeline register: hold > flush > bubble > normal advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= BUBBLE_CTRL;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct4   <= '0;
        end else if (hold) begin
            ex_valid    <= ex_valid;
        end else if (flush) begin
            // squashed slot: payload is don't-care, so it simply tracks ID
            ex_valid    <= 1'b0;
            ex_ctrl     <= BUBBLE_CTRL;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct4   <= id_funct4;
        end else if (load_use_stall) begin
            // ex_rd=0 keeps the forwarding unit from matching the bubble
            ex_valid    <= 1'b0;
            ex_ctrl     <= BUBBLE_CTRL;
            ex_rd       <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_valid ? id_ctrl : BUBBLE_CTRL;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct4   <= id_funct4;
        end
    end

    // Saturating bubble counter; flush already masks load_use_stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!hold && load_use_stall && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: a reference model predicts the EX-side outputs
// for each driven cycle, pushes them to a scoreboard queue, and the entry is
// popped and compared after the clock edge.
module tb_id_ex_stage_reg;

    localparam logic [7:0] C_LD   = 8'hD8;
    localparam logic [7:0] C_ADD  = 8'h82;
    localparam logic [7:0] C_ADDI = 8'h8B;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_uses_rs2;
    logic [63:0] id_rs1_data;
    logic [63:0] id_rs2_data;
    logic [63:0] id_imm;
    logic [3:0]  id_funct4;
    logic [7:0]  id_ctrl;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_rs1_data;
    logic [63:0] ex_rs2_data;
    logic [63:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_funct4;
    logic [7:0]  ex_ctrl;
    logic        load_use_stall;
    logic [3:0]  bubble_cnt;

    id_ex_stage_reg #(.XLEN(64), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .hold           (hold),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_uses_rs2    (id_uses_rs2),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_funct4      (id_funct4),
        .id_ctrl        (id_ctrl),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_funct4      (ex_funct4),
        .ex_ctrl        (ex_ctrl),
        .load_use_stall (load_use_stall),
        .bubble_cnt     (bubble_cnt)
    );

    typedef struct {
        logic        valid;
        logic [63:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        uses;
        logic [3:0]  f4;
        logic [7:0]  ctrl;
    } id_t;

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        logic        rd_known;
        logic        data_known;
        logic [63:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2;
        logic [3:0]  f4;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic id_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u, input logic [7:0] c);
        id_t s;
        s.valid = v;
        s.rd    = rd;
        s.rs1   = rs1;
        s.rs2   = rs2;
        s.uses  = u;
        s.ctrl  = c;
        s.pc    = {$urandom, $urandom};
        s.d1    = {$urandom, $urandom};
        s.d2    = {$urandom, $urandom};
        s.imm   = {$urandom, $urandom};
        s.f4    = 4'($urandom);
        return s;
    endfunction

    task automatic model_reset();
        m.valid      = 1'b0;
        m.ctrl       = 8'h00;
        m.rd         = 5'd0;
        m.rd_known   = 1'b1;
        m.data_known = 1'b1;
        m.pc         = '0;
        m.d1         = '0;
        m.d2         = '0;
        m.imm        = '0;
        m.rs1        = '0;
        m.rs2        = '0;
        m.f4         = '0;
        m.cnt        = '0;
    endtask

    task automatic drive(input id_t s, input logic h, input logic f);
        id_valid    = s.valid;
        id_pc       = s.pc;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_rd       = s.rd;
        id_uses_rs2 = s.uses;
        id_rs1_data = s.d1;
        id_rs2_data = s.d2;
        id_imm      = s.imm;
        id_funct4   = s.f4;
        id_ctrl     = s.ctrl;
        hold        = h;
        flush       = f;
    endtask

    task automatic compare_out(input exp_t e);
        check_val("ex_valid", ex_valid, e.valid);
        check_val("ex_ctrl", ex_ctrl, e.ctrl);
        check_val("bubble_cnt", bubble_cnt, e.cnt);
        if (e.rd_known) check_val("ex_rd", ex_rd, e.rd);
        if (e.data_known) begin
            check_val("ex_pc", ex_pc, e.pc);
            check_val("ex_rs1_data", ex_rs1_data, e.d1);
            check_val("ex_rs2_data", ex_rs2_data, e.d2);
            check_val("ex_imm", ex_imm, e.imm);
            check_val("ex_rs1", ex_rs1, e.rs1);
            check_val("ex_rs2", ex_rs2, e.rs2);
            check_val("ex_funct4", ex_funct4, e.f4);
        end
    endtask

    // One cycle: drive at negedge, check stall, predict, clock, compare
    task automatic step(input id_t s, input logic h, input logic f);
        logic exp_stall;
        exp_t e;
        drive(s, h, f);
        #1;
        exp_stall = !f && m.valid && m.ctrl[6] && (m.rd != 5'd0) && s.valid &&
                    ((m.rd == s.rs1) || (s.uses && (m.rd == s.rs2)));
        check_val("load_use_stall", load_use_stall, exp_stall);
        if (h) begin
            // everything frozen
        end else if (f) begin
            m.valid = 1'b0; m.ctrl = 8'h00; m.rd = s.rd;
            m.rd_known = 1'b0; m.data_known = 1'b0;
        end else if (exp_stall) begin
            m.valid = 1'b0; m.ctrl = 8'h00; m.rd = 5'd0;
            m.rd_known = 1'b1; m.data_known = 1'b0;
            if (m.cnt != 4'hF) m.cnt = m.cnt + 4'd1;
        end else begin
            m.valid = s.valid; m.ctrl = s.valid ? s.ctrl : 8'h00; m.rd = s.rd;
            m.rd_known = 1'b1; m.data_known = 1'b1;
            m.pc = s.pc; m.d1 = s.d1; m.d2 = s.d2; m.imm = s.imm;
            m.rs1 = s.rs1; m.rs2 = s.rs2; m.f4 = s.f4;
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 1'b1, 1'b0);
        end else begin
            e = sb_q.pop_front();
            compare_out(e);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, ex_valid, 1'b0);
        check_val({tag, "_ctrl"}, ex_ctrl, 8'h00);
        check_val({tag, "_pc"}, ex_pc, 64'h0);
        check_val({tag, "_d1"}, ex_rs1_data, 64'h0);
        check_val({tag, "_d2"}, ex_rs2_data, 64'h0);
        check_val({tag, "_imm"}, ex_imm, 64'h0);
        check_val({tag, "_rs1"}, ex_rs1, 5'd0);
        check_val({tag, "_rs2"}, ex_rs2, 5'd0);
        check_val({tag, "_rd"}, ex_rd, 5'd0);
        check_val({tag, "_f4"}, ex_funct4, 4'd0);
        check_val({tag, "_cnt"}, bubble_cnt, 4'd0);
        check_val({tag, "_stall"}, load_use_stall, 1'b0);
    endtask

    initial begin
        id_t idle, ld5, ld0, add5, add0, addi;
        reset = 1'b1;
        idle  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00);
        drive(idle, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // 1: ld x5 ; add x6,x5,x7 -> one bubble, add enters after
        ld5  = mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b0, C_LD);
        add5 = mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, C_ADD);
        step(ld5, 1'b0, 1'b0);
        step(add5, 1'b0, 1'b0);
        check_val("t1_bubble_valid", ex_valid, 1'b0);
        check_val("t1_bubble_cnt", bubble_cnt, 4'd1);
        step(add5, 1'b0, 1'b0);
        check_val("t1_add_rd", ex_rd, 5'd6);
        check_val("t1_add_ctrl", ex_ctrl, C_ADD);
        step(idle, 1'b0, 1'b0);

        // 2: ld x0 ; add x6,x0,x1 -> no stall
        ld0  = mk(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, C_LD);
        add0 = mk(1'b1, 5'd6, 5'd0, 5'd1, 1'b1, C_ADD);
        step(ld0, 1'b0, 1'b0);
        step(add0, 1'b0, 1'b0);
        check_val("t2_add_valid", ex_valid, 1'b1);
        step(idle, 1'b0, 1'b0);

        // 3: ld x5 ; addi x6,x8,4 with rs2 field 5 unused -> no stall
        addi = mk(1'b1, 5'd6, 5'd8, 5'd5, 1'b0, C_ADDI);
        addi.imm = 64'd4;
        step(ld5, 1'b0, 1'b0);
        step(addi, 1'b0, 1'b0);
        check_val("t3_addi_imm", ex_imm, 64'd4);
        step(idle, 1'b0, 1'b0);

        // 4: flush coincides with hazard -> no stall, slot squashed
        step(ld5, 1'b0, 1'b0);
        step(add5, 1'b0, 1'b1);
        check_val("t4_cnt_same", bubble_cnt, 4'd1);
        step(idle, 1'b0, 1'b0);

        // 5: hold for 3 cycles during hazard, then exactly one bubble
        step(ld5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(add5, 1'b1, 1'b0);
        check_val("t5_held_ctrl", ex_ctrl, C_LD);
        step(add5, 1'b0, 1'b0);
        check_val("t5_cnt", bubble_cnt, 4'd2);
        step(add5, 1'b0, 1'b0);
        check_val("t5_add_valid", ex_valid, 1'b1);
        step(idle, 1'b0, 1'b0);

        // 6: 16 hazards saturate the 4-bit counter
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(ld5, 1'b0, 1'b0);
            step(add5, 1'b0, 1'b0);
            step(add5, 1'b0, 1'b0);
        end
        check_val("t6_sat", bubble_cnt, 4'hF);

        // async reset between edges clears everything at once
        step(ld5, 1'b0, 1'b0);
        drive(add5, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb_q.delete();
        step(add5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
